// File: rtl/moore_ser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : moore_ser_pkg
// Brief    : Shared state type and frame-length helper for the bit serializer.
//            Optional macro SER_PARITY_EN adds one trailing parity bit per frame.
// Revision : 1.0 - initial release
// ============================================================================
package moore_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    function automatic int frame_len(input int data_w);
`ifdef SER_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/moore_ser_shiftreg.sv
`default_nettype none
// ============================================================================
// Module   : moore_ser_shiftreg
// Brief    : Parallel-load shift register exposing the bit currently on the
//            serial output; shift direction fixed by MSB_FIRST.
// Revision : 1.0 - initial release
// ============================================================================
module moore_ser_shiftreg #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_shift,
    output logic              o_cur_bit
);

    logic [DATA_W-1:0] r_sh;
    logic [DATA_W-1:0] w_sh_next;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sh_next = {r_sh[DATA_W-2:0], 1'b0};
            assign o_cur_bit = r_sh[DATA_W-1];
        end else begin : g_lsb_first
            assign w_sh_next = {1'b0, r_sh[DATA_W-1:1]};
            assign o_cur_bit = r_sh[0];
        end
    endgenerate

    // Load has priority so a back-to-back accept on the last bit reloads cleanly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= w_sh_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/moore_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : moore_bit_serializer
// Brief    : Valid/ready parallel-to-serial feeder for the Moore detector, with
//            optional inter-frame gap. Macro SER_PARITY_EN appends even parity.
// Revision : 1.0 - initial release
// ============================================================================
module moore_bit_serializer
    import moore_ser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int GAP_CYC   = 0,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              busy,
    output logic              word_done
);

    localparam int               c_FRAME_LEN = frame_len(DATA_W);
    localparam int               c_CNT_W     = $clog2(c_FRAME_LEN);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(c_FRAME_LEN - 1);
    localparam logic [3:0]       c_GAP_LAST  = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam bit               c_NO_GAP    = (GAP_CYC == 0);

    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_SHIFT = SHIFT;
    localparam logic [1:0] c_ST_GAP   = GAP;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [3:0]         r_gap_cnt;

    logic w_in_shift;
    logic w_last;
    logic w_in_ready;
    logic w_accept;
    logic w_shift;
    logic w_data_bit;
    logic w_cur_bit;

    assign w_in_shift = (r_state == c_ST_SHIFT);
    assign w_last     = w_in_shift && (r_bit_cnt == c_LAST);
    assign w_in_ready = (r_state == c_ST_IDLE) || (w_last && c_NO_GAP);
    assign w_accept   = in_valid && w_in_ready;
    assign w_shift    = w_in_shift && !w_last;

    moore_ser_shiftreg #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shiftreg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_data    (in_data),
        .i_shift   (w_shift),
        .o_cur_bit (w_data_bit)
    );

`ifdef SER_PARITY_EN
    localparam logic [c_CNT_W-1:0] c_PAR_IDX = c_CNT_W'(DATA_W);
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^in_data;
        end
    end

    assign w_cur_bit = (r_bit_cnt == c_PAR_IDX) ? r_parity : w_data_bit;
`else
    assign w_cur_bit = w_data_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= c_ST_SHIFT;
                        r_bit_cnt <= '0;
                    end
                end
                c_ST_SHIFT: begin
                    if (!w_last) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else if (w_accept) begin
                        r_bit_cnt <= '0;
                    end else if (c_NO_GAP) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_state   <= c_ST_GAP;
                        r_gap_cnt <= '0;
                    end
                end
                c_ST_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // All outputs decode registered state, so they change only on clock edges
    assign in_ready  = w_in_ready;
    assign ser_valid = w_in_shift;
    assign ser_bit   = w_in_shift & w_cur_bit;
    assign busy      = (r_state != c_ST_IDLE);
    assign word_done = w_last;

endmodule
`default_nettype wire

// File: tb/tb_moore_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_moore_bit_serializer
// Brief    : Scoreboard bench for moore_bit_serializer (three configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_moore_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int FRAME_LEN = 9;
`else
    localparam int FRAME_LEN = 8;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] in_data [3];
    logic [2:0] in_valid;
    wire  [2:0] in_ready;
    wire  [2:0] ser_bit;
    wire  [2:0] ser_valid;
    wire  [2:0] busy;
    wire  [2:0] word_done;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q [3][$];
    logic       mon_en = 1'b0;
    logic [2:0] prev_valid = '0;
    int         idle_run [3] = '{0, 0, 0};
    int         last_gap [3] = '{0, 0, 0};
    int         n_starts [3] = '{0, 0, 0};

    // inst 0: MSB first, no gap; inst 1: LSB first, no gap; inst 2: MSB first, 2 gap
    moore_bit_serializer #(.DATA_W(8), .GAP_CYC(0), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .ser_bit(ser_bit[0]), .ser_valid(ser_valid[0]),
        .busy(busy[0]), .word_done(word_done[0]));

    moore_bit_serializer #(.DATA_W(8), .GAP_CYC(0), .MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .ser_bit(ser_bit[1]), .ser_valid(ser_valid[1]),
        .busy(busy[1]), .word_done(word_done[1]));

    moore_bit_serializer #(.DATA_W(8), .GAP_CYC(2), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .ser_bit(ser_bit[2]), .ser_valid(ser_valid[2]),
        .busy(busy[2]), .word_done(word_done[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%0h required=%0h", nm, k, act, req);
        end
    endtask

    // Expected serial stream: {bit, word_done}
    task automatic push_word(input int k, input logic [7:0] d);
        logic b;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i == 8) b = ^d;
            else if (k == 1) b = d[i];
            else b = d[7-i];
            exp_q[k].push_back({b, (i == FRAME_LEN - 1)});
        end
    endtask

    task automatic send(input int k, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (in_ready[k] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", k, 32'd0, 32'd1);
            in_valid[k] = 1'b0;
        end else begin
            push_word(k, d);
            @(posedge clk);
        end
    endtask

    task automatic idle(input int k);
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0
                && busy === 3'b000) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops one expectation per ser_valid cycle, checks idle outputs otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (ser_valid[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        chk("unexpected_bit", k, 32'd1, 32'd0);
                    end else begin
                        logic [1:0] e;
                        e = exp_q[k].pop_front();
                        chk("ser_bit", k, {31'd0, ser_bit[k]}, {31'd0, e[1]});
                        chk("word_done", k, {31'd0, word_done[k]}, {31'd0, e[0]});
                        chk("in_ready_shift", k, {31'd0, in_ready[k]},
                            {31'd0, (k < 2) ? e[0] : 1'b0});
                    end
                    if (!prev_valid[k]) begin
                        last_gap[k] = idle_run[k];
                        n_starts[k]++;
                    end
                    idle_run[k] = 0;
                end else begin
                    chk("idle_ser_bit", k, {31'd0, ser_bit[k]}, 32'd0);
                    chk("idle_word_done", k, {31'd0, word_done[k]}, 32'd0);
                    chk("idle_in_ready", k, {31'd0, in_ready[k]}, {31'd0, ~busy[k]});
                    idle_run[k]++;
                end
                prev_valid[k] = ser_valid[k];
            end
        end
    end

    initial begin
        int s0;
        rst      = 1'b1;
        in_valid = '0;
        for (int k = 0; k < 3; k++) in_data[k] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_ser_valid", k, {31'd0, ser_valid[k]}, 32'd0);
            chk("rst_ser_bit",   k, {31'd0, ser_bit[k]},   32'd0);
            chk("rst_busy",      k, {31'd0, busy[k]},      32'd0);
            chk("rst_word_done", k, {31'd0, word_done[k]}, 32'd0);
            chk("rst_in_ready",  k, {31'd0, in_ready[k]},  32'd1);
        end
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single words: B4 MSB-first, 01 LSB-first
        send(0, 8'hB4); idle(0);
        send(1, 8'h01); idle(1);
        drain();

        // Back-to-back FF then 00 with in_valid held: one contiguous run
        s0 = n_starts[0];
        send(0, 8'hFF); send(0, 8'h00); idle(0);
        send(1, 8'h80); send(1, 8'h7E); idle(1);
        drain();
        chk("b2b_no_bubble", 0, n_starts[0], s0 + 1);

        // Gap instance: two words, 2 gap cycles + 1 idle accept cycle between
        send(2, 8'h3C); send(2, 8'hC3); idle(2);
        drain();
        chk("gap_length", 2, last_gap[2], 3);
        chk("gap_frames", 2, n_starts[2], 2);

        // Reset during bit 3 of AA aborts the frame
        send(0, 8'hAA);
        idle(0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q[0].delete();
        @(negedge clk);
        chk("abort_ser_valid", 0, {31'd0, ser_valid[0]}, 32'd0);
        chk("abort_busy",      0, {31'd0, busy[0]},      32'd0);
        chk("abort_in_ready",  0, {31'd0, in_ready[0]},  32'd1);
        chk("abort_word_done", 0, {31'd0, word_done[0]}, 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_no_restart", 0, {31'd0, busy[0]}, 32'd0);

        // B4/B5 back-to-back: parity differs when the parity bit is enabled
        send(0, 8'hB4); send(0, 8'hB5); idle(0);
        drain();

        // in_valid low: stays idle, outputs static
        repeat (20) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("final_busy", k, {31'd0, busy[k]}, 32'd0);
            chk("queue_empty", k, exp_q[k].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
